fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised successor to the single-word IF stage. It decouples fetch from decode with a prefetch queue.
- Issues pipelined requests over a valid/ready instruction-memory interface and tolerates variable response latency.
- On a branch/jump redirect it flushes the queue and discards stale in-flight responses.
- Sits between the program-counter/redirect logic (EX stage) and the IF/ID register; the decode stage is the consumer.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QUEUE_DEPTH, 4, prefetch queue entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (>=1, <=QUEUE_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- redirect_valid  in  1  branch/jump taken; restart fetch.
- redirect_pc  in  XLEN  new fetch address; bits[1:0] ignored (forced 0).
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses arrive in order, always accepted.
- imem_rsp_data  in  XLEN  instruction word.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts (deasserted on stall).
- out_pc  out  XLEN  PC of out_instr.
- out_instr  out  XLEN  instruction word.
- debug_fetch_pc  out  XLEN  next address to be requested.

Behaviour:
Reset:
- Reset is synchronous and active-high on rst, single clock clk.
- After reset: fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0.
- Output values after reset: out_valid=0, out_pc=0, out_instr=0, imem_req_valid=0.

Issue:
- imem_req_valid=1 iff !rst && !redirect_valid && outstanding<MAX_OUTSTANDING && (count+outstanding)<QUEUE_DEPTH.
- The credit rule guarantees the queue never overflows.
- imem_req_addr=fetch_pc. On accept (valid&&ready): push fetch_pc into the in-flight PC FIFO (depth MAX_OUTSTANDING), fetch_pc+=4, outstanding++.
- Address wraps modulo 2^XLEN.
- Earliest first request: first cycle after rst deasserts.

Response:
- Each imem_rsp_valid pops the in-flight PC FIFO and decrements outstanding.
- If discard>0: drop the response and decrement discard.
- Otherwise push {pc,instr} into the queue.
- imem_rsp_valid with outstanding==0 is a protocol error: ignored, no state change (simulation assertion).
- Same-cycle accept and response: outstanding unchanged.

Output:
- out_valid = queue non-empty. out_pc/out_instr = queue head; registered, no bypass. A response is visible to decode the cycle after it arrives.
- Pop on out_valid&&out_ready. Head is held stable while out_valid&&!out_ready.
- Queue push and pop in the same cycle are allowed, including when the queue is full.

Redirect (single cycle):
- Queue cleared (count=0 next cycle). fetch_pc=redirect_pc&~3. No request issued that cycle.
- discard = outstanding after this cycle's response decrement. Any response arriving in the redirect cycle is itself dropped.
- The in-flight PC FIFO is not cleared; entries pop as the stale responses drain.
- An out handshake in the redirect cycle completes normally (decode owns that word).
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- New requests may issue while discard>0, subject to credits. Their responses are kept because ordering guarantees the stale ones come first.

Reset mid-operation: all state returns to reset values; pending responses after reset are treated as a protocol error.

Decomposition:
- Shared package core_pkg: XLEN, RESET_PC default, fetch_entry_t struct {pc, instr}, ILEN_BYTES=4.
- Sub-module sync_fifo (parametrised WIDTH/DEPTH, clear input, count output).
  - Used twice: the prefetch queue (fetch_entry_t) and the in-flight PC FIFO.
- Top level holds fetch_pc, outstanding and discard counters, and issue/redirect logic.

Test Plan:
- Streaming: reset, ready=1, 1-cycle latency, out_ready=1 → requests 0x0,0x4,0x8…. First out_valid 2 cycles after first accept, out_pc=0x0. Then one instruction per cycle.
- Backpressure: out_ready=0 for 10 cycles → queue fills to 4 and imem_req_valid=0. Head stays pc=0x0 and stable. Release → pcs 0x0..0xC delivered in order, fetch resumes at 0x10.
- Redirect with 2 outstanding: latency 3, redirect_pc=0x104 → next out_pc=0x104, requested addr 0x104. The two stale responses are never delivered.
- Redirect coincident with a response and an out handshake → the handshaken word is consumed once. The coincident response is dropped. Next out_pc = redirect target.
- Back-to-back redirects 0x200 then 0x300 → only 0x300 stream appears; no 0x200 word delivered.
- Wrap and alignment: RESET_PC=0xFFFF_FFF8 → pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. redirect_pc=0x1003 → fetch 0x1000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset fetch address and the
// prefetch-queue entry layout used between fetch and decode.
// Latency: n/a (types and constants only). Backpressure: n/a.
package core_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
  localparam int              ILEN_BYTES       = 4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count and a single-cycle clear.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens the same cycle.
//
// Ports: clk/rst (sync, active-high), clear (empty the FIFO), push/push_data,
//        pop, head (current oldest word), count, empty, full.
module sync_fifo #(
  parameter int   WIDTH = 8,
  parameter int   DEPTH = 4,
  localparam int  AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int  CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths (e.g. one outstanding) legal.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; readers only look at head while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with a prefetch queue, pipelined imem requests and redirect flush.
// Latency: response reaches decode the cycle after it arrives; first request the cycle after reset.
// Backpressure: out_ready low holds the head; issue stops once queue+outstanding credits run out.
//
// Ports: clk, rst (sync, active-high); redirect_valid/redirect_pc from EX;
//        imem_req_valid/ready/addr and imem_rsp_valid/data to instruction memory;
//        out_valid/ready/pc/instr to decode; debug_fetch_pc = next address to request.
module fetch_unit #(
  parameter int                 XLEN            = core_pkg::XLEN,
  parameter logic [XLEN-1:0]    RESET_PC        = core_pkg::RESET_PC_DEFAULT,
  parameter int                 QUEUE_DEPTH     = 4,
  parameter int                 MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] debug_fetch_pc
);

  import core_pkg::*;

  // Queue entries use the shared fetch_entry_t layout, so XLEN tracks the package width.
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(QUEUE_DEPTH + 1);
  localparam int SW = QW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard;
  logic [OW-1:0]   outstanding_after_rsp;
  logic [SW-1:0]   credits_used;

  logic            rsp_ok;
  logic            accept;
  logic            drop;
  logic            q_push;
  logic            q_pop;

  fetch_entry_t    q_in;
  fetch_entry_t    q_head;
  logic [QW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;

  logic [XLEN-1:0] inflight_pc;
  logic [OW-1:0]   pf_count;
  logic            pf_empty;
  logic            pf_full;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok = imem_rsp_valid && (outstanding != '0);

  // Every outstanding request owns a queue slot, so the queue can never overflow.
  assign credits_used   = SW'(q_count) + SW'(outstanding);
  assign imem_req_valid = !rst && !redirect_valid
                          && (outstanding < OW'(MAX_OUTSTANDING))
                          && (credits_used < SW'(QUEUE_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign outstanding_after_rsp = outstanding - OW'(rsp_ok);

  // Stale responses (pending discard, or arriving in the redirect cycle) never enter the queue.
  assign drop   = redirect_valid || (discard != '0);
  assign q_push = rsp_ok && !drop;
  assign q_pop  = out_valid && out_ready;

  assign q_in.pc    = inflight_pc;
  assign q_in.instr = imem_rsp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_after_rsp + OW'(accept);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~XLEN'(ILEN_BYTES - 1);
        // Everything still in flight after this cycle belongs to the old path.
        discard  <= outstanding_after_rsp;
      end else begin
        if (accept)                 fetch_pc <= fetch_pc + XLEN'(ILEN_BYTES);
        if (rsp_ok && discard != '0) discard <= discard - 1'b1;
      end
    end
  end

  // Prefetch queue: cleared on redirect; a pop in that cycle still completes for decode.
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // In-flight PCs are never flushed: stale entries drain as their responses return.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_ok),
    .head      (inflight_pc),
    .count     (pf_count),
    .empty     (pf_empty),
    .full      (pf_full)
  );

  assign out_valid      = !q_empty;
  assign out_pc         = out_valid ? q_head.pc    : '0;
  assign out_instr      = out_valid ? q_head.instr : '0;
  assign debug_fetch_pc = fetch_pc;

  a_rsp_protocol: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && outstanding == '0));
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(q_push && q_full && !q_pop));
  a_inflight_tracks: assert property (@(posedge clk) disable iff (rst)
    pf_count == outstanding);
  a_inflight_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_ok && pf_empty));
  a_inflight_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(accept && pf_full));

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam int          MAXO   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] debug_fetch_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(32), .RESET_PC(RST_PC), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .debug_fetch_pc(debug_fetch_pc)
  );

  typedef struct packed { logic [31:0] addr; int due; } mreq_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       pend[$];   // accepted requests awaiting a memory response, in order
  exp_t        exp_q[$];  // words decode is expected to receive next
  logic [31:0] stream_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_count = 0;
  int first_acc = -1, first_out = -1, rel_cyc = -1;

  // Stimulus knobs
  logic        k_rst = 1'b1, k_redir = 1'b0, k_ordy = 1'b1, k_qrdy = 1'b1;
  logic [31:0] k_rpc = 32'h0;
  int          lat_min = 1, lat_max = 1;

  // Per-cycle samples taken by the driver
  logic        rsp_now, s_acc, s_out_hs;
  logic [31:0] s_addr, s_out_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at negedge, sample handshakes, update memory and expected stream.
  task automatic step();
    int lat;
    int due;
    @(negedge clk);
    cyc++;
    rst            = k_rst;
    redirect_valid = k_redir;
    redirect_pc    = k_rpc;
    out_ready      = k_ordy;
    imem_req_ready = k_qrdy;
    rsp_now = 1'b0;
    if (!k_rst && pend.size() > 0) rsp_now = (pend[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    if (rsp_now) imem_rsp_data = mem_word(pend[0].addr);
    else         imem_rsp_data = $urandom();
    #1;
    s_acc    = imem_req_valid && imem_req_ready;
    s_addr   = imem_req_addr;
    s_out_hs = out_valid && out_ready;
    s_out_pc = out_pc;
    @(posedge clk);
    #1;
    if (rsp_now) void'(pend.pop_front());
    if (s_acc) begin
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
      pend.push_back('{addr: s_addr, due: due});
    end
    if (k_rst) begin
      pend.delete();
      exp_q.delete();
      stream_pc = RST_PC;
    end else if (k_redir) begin
      exp_q.delete();
      stream_pc = k_rpc & ~32'h3;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: stream_pc, instr: mem_word(stream_pc)});
      stream_pc += 32'd4;
    end
  endtask

  task automatic do_reset();
    k_rst = 1'b1; k_redir = 1'b0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_fetch_pc", debug_fetch_pc, RST_PC);
    k_rst = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [31:0] want);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (s_out_hs) begin
        seen = 1'b1;
        chk(name, s_out_pc, want);
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no output within 40 cycles, expected pc 0x%08h", name, want);
    end
  endtask

  // Monitor: compares every decode handshake and request against the scoreboard.
  logic [31:0] exp_req, prev_pc, prev_instr;
  logic        prev_stall = 1'b0;
  exp_t        mon_e;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_req    = RST_PC;
      prev_stall = 1'b0;
      first_acc  = -1;
      first_out  = -1;
      rel_cyc    = -1;
      chk("req_valid_in_reset", imem_req_valid, 0);
    end else begin
      if (rel_cyc < 0) rel_cyc = cyc;
      if (out_valid && first_out < 0) first_out = cyc;
      if (prev_stall) begin
        chk("head_hold_valid", out_valid, 1);
        chk("head_hold_pc", out_pc, prev_pc);
        chk("head_hold_instr", out_instr, prev_instr);
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out_unexpected: got pc 0x%08h, expected no word", out_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_pc", out_pc, mon_e.pc);
          chk("out_instr", out_instr, mon_e.instr);
        end
      end
      if (redirect_valid) chk("no_req_on_redirect", imem_req_valid, 0);
      if (imem_req_valid) chk("outstanding_limit", pend.size() < MAXO, 1);
      if (imem_req_valid && imem_req_ready) begin
        if (first_acc < 0) first_acc = cyc;
        chk("req_addr", imem_req_addr, exp_req);
        exp_req += 32'd4;
      end
      if (redirect_valid) exp_req = redirect_pc & ~32'h3;
      prev_stall = out_valid && !out_ready && !redirect_valid;
      prev_pc    = out_pc;
      prev_instr = out_instr;
    end
  end

  initial begin
    int h0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;

    // Streaming, 1-cycle memory
    lat_min = 1; lat_max = 1; k_ordy = 1'b1; k_qrdy = 1'b1;
    do_reset();
    repeat (4) step();
    h0 = hs_count;
    repeat (10) step();
    chk("stream_rate", hs_count - h0, 10);
    chk("first_req_cycle", first_acc, rel_cyc);
    chk("first_out_delay", first_out - first_acc, 2);

    // Backpressure fills the queue and stops issue
    do_reset();
    k_ordy = 1'b0;
    repeat (10) step();
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head_pc", out_pc, 32'h0);
    chk("bp_fetch_pc", debug_fetch_pc, 32'h10);
    k_ordy = 1'b1;
    wait_out("bp_release_first", 32'h0);
    repeat (6) step();

    // Redirect with two requests in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && pend.size() < 2; i++) step();
    chk("two_outstanding", pend.size(), 2);
    k_redir = 1'b1; k_rpc = 32'h104; step(); k_redir = 1'b0;
    wait_out("redir_first", 32'h104);
    repeat (8) step();

    // Redirect coinciding with a response and a decode handshake
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 30; i++) begin
      if (out_valid && pend.size() > 0 && pend[0].due <= cyc + 1) break;
      step();
    end
    k_redir = 1'b1; k_rpc = 32'h180; step(); k_redir = 1'b0;
    chk("coinc_out_hs", s_out_hs, 1);
    chk("coinc_rsp", rsp_now, 1);
    wait_out("coinc_next", 32'h180);
    repeat (6) step();

    // Back-to-back redirects: the second wins
    k_redir = 1'b1; k_rpc = 32'h200; step();
    k_rpc = 32'h300; step(); k_redir = 1'b0;
    wait_out("b2b_first", 32'h300);
    repeat (8) step();

    // Alignment and address wrap
    k_redir = 1'b1; k_rpc = 32'hFFFF_FFF7; step(); k_redir = 1'b0;
    chk("align_wrap_fetch_pc", debug_fetch_pc, 32'hFFFF_FFF4);
    wait_out("wrap_first", 32'hFFFF_FFF4);
    repeat (8) step();
    k_redir = 1'b1; k_rpc = 32'h1003; step(); k_redir = 1'b0;
    chk("align_fetch_pc", debug_fetch_pc, 32'h1000);
    wait_out("align_first", 32'h1000);

    // Randomised traffic with a reset in the middle
    lat_min = 1; lat_max = 4;
    h0 = hs_count;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      k_ordy  = ($urandom_range(3, 0) != 0);
      k_qrdy  = ($urandom_range(3, 0) != 0);
      k_redir = ($urandom_range(31, 0) == 0);
      k_rpc   = $urandom();
      step();
    end
    k_redir = 1'b0; k_ordy = 1'b1; k_qrdy = 1'b1;
    repeat (20) step();
    chk("random_progress", (hs_count - h0) > 300, 1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
